// File: rtl/npc_pkg.sv
// Shared types and helpers for the next-PC fetch unit: branch opcode encoding and default vectors.
package npc_pkg;

  typedef enum logic [3:0] {
    NONE, BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ, J, JAL, JR, JALR
  } br_op_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

  function automatic logic is_link(br_op_e op);
    return (op == JAL) || (op == JALR);
  endfunction

  function automatic logic is_reg_jump(br_op_e op);
    return (op == JR) || (op == JALR);
  endfunction

endpackage

// File: rtl/npc_fetch_unit_if.sv
// Bundle between the D stage / CP0 / hazard unit (master) and the next-PC unit (slave).
interface npc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) ();
  import npc_pkg::*;

  logic              req;
  logic              eret;
  logic [ADDR_W-1:0] epc;
  logic              stall;
  logic              d_valid;
  br_op_e            br_op;
  logic              cmp_eq;
  logic              cmp_gtz;
  logic              cmp_ltz;
  logic [ADDR_W-1:0] d_pc;
  logic [25:0]       imm26;
  logic [ADDR_W-1:0] rs_val;
  logic [ADDR_W-1:0] f_pc;
  logic              redirect;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_hit;
  logic [CNT_W-1:0]  jr_total;
  logic [CNT_W-1:0]  jr_hit;

  modport master (
    output req, eret, epc, stall, d_valid, br_op, cmp_eq, cmp_gtz, cmp_ltz, d_pc, imm26, rs_val,
    input  f_pc, redirect, ras_top, ras_empty, ras_hit, jr_total, jr_hit
  );

  modport slave (
    input  req, eret, epc, stall, d_valid, br_op, cmp_eq, cmp_gtz, cmp_ltz, d_pc, imm26, rs_val,
    output f_pc, redirect, ras_top, ras_empty, ras_hit, jr_total, jr_hit
  );

endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack; pushing when full overwrites the oldest entry.
module npc_ras #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              replace_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] entries_q [RAS_DEPTH];
  logic [PtrW-1:0]   ptr_q, ptr_d, top_idx, waddr;
  logic [CntW-1:0]   count_q, count_d;
  logic              we;

  // ptr_q is the next slot to write; the top lives one below it.
  assign top_idx = ptr_q - 1'b1;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(RAS_DEPTH));
  assign top_o   = empty_o ? '0 : entries_q[top_idx];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = ptr_q;
    if (replace_i) begin
      we = 1'b1;
      if (empty_o) begin
        ptr_d   = ptr_q + 1'b1;
        count_d = CntW'(1);
      end else begin
        waddr = top_idx;
      end
    end else if (push_i) begin
      we    = 1'b1;
      ptr_d = ptr_q + 1'b1;
      if (!full_o) count_d = count_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d   = top_idx;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) entries_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (we) entries_q[waddr] <= data_i;
    end
  end

endmodule

// File: rtl/npc_fetch_unit.sv
// F-stage PC register with redirect priority, return-address stack and jr/jalr hit counters.
module npc_fetch_unit
  import npc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEFAULT_EXC_VEC),
  parameter int unsigned       RAS_DEPTH = 8,
  parameter int unsigned       CNT_W     = 16
) (
  input logic             clk,
  input logic             reset,
  npc_fetch_unit_if.slave bus
);

  logic              adv, taken, reg_jump, ras_empty, ras_full;
  logic [ADDR_W-1:0] f_pc_q, f_pc_d, seq_pc, offset, br_tgt, jmp_tgt, tgt, link_addr, ras_top;
  logic [CNT_W-1:0]  jr_total_q, jr_hit_q;
  logic              ras_hit;

  // A D instruction only acts when nothing of higher priority claims the cycle.
  assign adv       = bus.d_valid & ~bus.stall & ~bus.req & ~bus.eret;
  assign seq_pc    = f_pc_q + ADDR_W'(4);
  assign offset    = {{(ADDR_W - 18){bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
  assign br_tgt    = bus.d_pc + ADDR_W'(4) + offset;
  assign jmp_tgt   = {bus.d_pc[ADDR_W-1:28], bus.imm26, 2'b00};
  assign link_addr = bus.d_pc + ADDR_W'(8);
  assign reg_jump  = is_reg_jump(bus.br_op);

  always_comb begin
    taken = 1'b0;
    tgt   = br_tgt;
    unique case (bus.br_op)
      BEQ:     taken = bus.cmp_eq;
      BNE:     taken = ~bus.cmp_eq;
      BGTZ:    taken = bus.cmp_gtz;
      BLEZ:    taken = ~bus.cmp_gtz;
      BLTZ:    taken = bus.cmp_ltz;
      BGEZ:    taken = ~bus.cmp_ltz;
      J, JAL: begin
        taken = 1'b1;
        tgt   = jmp_tgt;
      end
      JR, JALR: begin
        taken = 1'b1;
        tgt   = bus.rs_val;
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (bus.req)              f_pc_d = EXC_VEC;
    else if (bus.eret)        f_pc_d = bus.epc;
    else if (bus.stall)       f_pc_d = f_pc_q;
    else if (adv && taken)    f_pc_d = tgt;
    else                      f_pc_d = seq_pc;
  end

  npc_ras #(
    .RAS_DEPTH(RAS_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push_i   (adv && (bus.br_op == JAL)),
    .pop_i    (adv && (bus.br_op == JR)),
    .replace_i(adv && (bus.br_op == JALR)),
    .data_i   (link_addr),
    .top_o    (ras_top),
    .empty_o  (ras_empty),
    .full_o   (ras_full)
  );

  // Compared against the pre-update top, before this cycle's pop/replace lands.
  assign ras_hit = adv & reg_jump & ~ras_empty & (ras_top == bus.rs_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q     <= RESET_PC;
      jr_total_q <= '0;
      jr_hit_q   <= '0;
    end else begin
      f_pc_q <= f_pc_d;
      if (adv && reg_jump && (jr_total_q != '1)) jr_total_q <= jr_total_q + 1'b1;
      if (ras_hit && (jr_hit_q != '1))           jr_hit_q   <= jr_hit_q + 1'b1;
    end
  end

  assign bus.f_pc      = f_pc_q;
  assign bus.redirect  = bus.req | bus.eret | (adv & taken) | (ras_full & 1'b0);
  assign bus.ras_top   = ras_top;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_hit   = ras_hit;
  assign bus.jr_total  = jr_total_q;
  assign bus.jr_hit    = jr_hit_q;

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Directed bench for npc_fetch_unit: redirect priority, branch targets, RAS and hit counters.
module tb_npc_fetch_unit;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  npc_fetch_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  npc_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_3000),
    .EXC_VEC  (32'h0000_4180),
    .RAS_DEPTH(8),
    .CNT_W    (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req     = 1'b0;
    bus.eret    = 1'b0;
    bus.epc     = '0;
    bus.stall   = 1'b0;
    bus.d_valid = 1'b0;
    bus.br_op   = NONE;
    bus.cmp_eq  = 1'b0;
    bus.cmp_gtz = 1'b0;
    bus.cmp_ltz = 1'b0;
    bus.d_pc    = '0;
    bus.imm26   = '0;
    bus.rs_val  = '0;
  endtask

  task automatic d_op(input br_op_e op, input logic [31:0] pc, input logic [25:0] imm,
                      input logic [31:0] rs);
    bus.d_valid = 1'b1;
    bus.br_op   = op;
    bus.d_pc    = pc;
    bus.imm26   = imm;
    bus.rs_val  = rs;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_f_pc", bus.f_pc, 32'h3000);
    chk("reset_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("reset_top", bus.ras_top, 32'h0);
    chk("reset_jr_total", {16'd0, bus.jr_total}, 32'd0);
    reset = 1'b0;
    #1 chk("seq_redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    chk("seq_3004", bus.f_pc, 32'h3004);
    tick();
    chk("seq_3008", bus.f_pc, 32'h3008);

    // BEQ backwards by -16 from d_pc+4
    d_op(BEQ, 32'h3010, 26'h000_FFFC, 32'h0);
    bus.cmp_eq = 1'b1;
    #1 chk("beq_taken_redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    chk("beq_taken_pc", bus.f_pc, 32'h3004);
    bus.cmp_eq = 1'b0;
    #1 chk("beq_nt_redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    chk("beq_nt_pc", bus.f_pc, 32'h3008);

    // Stall holds even a taken branch; req overrides the stall
    d_op(BNE, 32'h3010, 26'h000_0010, 32'h0);
    bus.cmp_eq = 1'b0;
    bus.stall  = 1'b1;
    #1 chk("stall_redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    chk("stall_hold1", bus.f_pc, 32'h3008);
    tick();
    chk("stall_hold2", bus.f_pc, 32'h3008);
    bus.req = 1'b1;
    #1 chk("req_redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    chk("req_exc_vec", bus.f_pc, 32'h4180);
    chk("req_ras_empty", {31'd0, bus.ras_empty}, 32'd1);
    idle();

    // JAL then matching JR
    d_op(JAL, 32'h3020, 26'h000_0C40, 32'h0);
    tick();
    chk("jal_target", bus.f_pc, 32'h3100);
    chk("jal_top", bus.ras_top, 32'h3028);
    d_op(JR, 32'h3104, 26'h0, 32'h3028);
    #1 chk("jr_hit_comb", {31'd0, bus.ras_hit}, 32'd1);
    tick();
    chk("jr_target", bus.f_pc, 32'h3028);
    chk("jr_total_1", {16'd0, bus.jr_total}, 32'd1);
    chk("jr_hit_1", {16'd0, bus.jr_hit}, 32'd1);
    chk("jr_empty", {31'd0, bus.ras_empty}, 32'd1);

    // Reset wins over pending req and stall
    reset     = 1'b1;
    bus.req   = 1'b1;
    bus.stall = 1'b1;
    tick();
    chk("reset_over_req", bus.f_pc, 32'h3000);
    chk("reset_clr_total", {16'd0, bus.jr_total}, 32'd0);
    reset = 1'b0;
    idle();

    // Nine pushes into an 8-deep stack: the first push is overwritten
    for (int i = 0; i < 9; i++) begin
      d_op(JAL, 32'h3200 + 32'(16 * i), 26'h0, 32'h0);
      tick();
    end
    chk("ovf_top", bus.ras_top, 32'h3288);
    for (int k = 0; k < 9; k++) begin
      logic [31:0] exp_ra;
      exp_ra = 32'h3200 + 32'(16 * (8 - k)) + 32'h8;
      d_op(JR, 32'h3000, 26'h0, exp_ra);
      #1 chk($sformatf("pop%0d_hit", k), {31'd0, bus.ras_hit}, (k < 8) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("pop%0d_pc", k), bus.f_pc, exp_ra);
    end
    chk("ovf_total", {16'd0, bus.jr_total}, 32'd9);
    chk("ovf_hit", {16'd0, bus.jr_hit}, 32'd8);
    chk("ovf_empty", {31'd0, bus.ras_empty}, 32'd1);

    // JALR on empty pushes; JALR on non-empty replaces the top
    d_op(JALR, 32'h3400, 26'h0, 32'h5000);
    #1 chk("jalr_empty_hit", {31'd0, bus.ras_hit}, 32'd0);
    tick();
    chk("jalr_pc", bus.f_pc, 32'h5000);
    chk("jalr_top1", bus.ras_top, 32'h3408);
    d_op(JALR, 32'h3500, 26'h0, 32'h3408);
    #1 chk("jalr_hit", {31'd0, bus.ras_hit}, 32'd1);
    tick();
    chk("jalr_top2", bus.ras_top, 32'h3508);
    d_op(JR, 32'h3600, 26'h0, 32'h3508);
    tick();
    chk("jalr_cnt_one", {31'd0, bus.ras_empty}, 32'd1);
    chk("jalr_total", {16'd0, bus.jr_total}, 32'd12);
    chk("jalr_hits", {16'd0, bus.jr_hit}, 32'd10);

    // Untaken conditions and bubbles
    d_op(BLTZ, 32'h3000, 26'h4, 32'h0);
    #1 chk("bltz_nt", {31'd0, bus.redirect}, 32'd0);
    bus.br_op   = BLEZ;
    bus.cmp_gtz = 1'b1;
    #1 chk("blez_nt", {31'd0, bus.redirect}, 32'd0);
    bus.br_op   = BGEZ;
    #1 chk("bgez_t", {31'd0, bus.redirect}, 32'd1);
    bus.br_op   = J;
    bus.d_valid = 1'b0;
    #1 chk("bubble_nt", {31'd0, bus.redirect}, 32'd0);
    idle();

    // eret beats a taken branch and a JR in D
    d_op(JAL, 32'h3600, 26'h0, 32'h0);
    tick();
    d_op(BGTZ, 32'h3700, 26'h40, 32'h0);
    bus.cmp_gtz = 1'b1;
    bus.eret    = 1'b1;
    bus.epc     = 32'h3100;
    #1 chk("eret_redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    chk("eret_pc", bus.f_pc, 32'h3100);
    chk("eret_top", bus.ras_top, 32'h3608);
    d_op(JR, 32'h3700, 26'h0, 32'h3608);
    #1 chk("eret_jr_nohit", {31'd0, bus.ras_hit}, 32'd0);
    tick();
    chk("eret_jr_pc", bus.f_pc, 32'h3100);
    chk("eret_jr_top", bus.ras_top, 32'h3608);
    chk("eret_total", {16'd0, bus.jr_total}, 32'd12);
    chk("eret_hits", {16'd0, bus.jr_hit}, 32'd10);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
